// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: logic/arith/compare/branch ops in one cycle, shifts iterate 1 bit per cycle.
// Latency: 1 cycle for non-shift ops and shamt=0 shifts; shamt+1 cycles for shifts with shamt>=1.
// Backpressure: result held stable until out_ready; in_ready low during a shift or a stalled result.
//
// Ports:
//   clk, reset (async, active-low), flush (sync kill of the in-flight and pending op)
//   in_valid/in_ready with Operation, SrcA, SrcB   : issue side
//   out_valid/out_ready with ALUResult, BranchTaken : result side (registered outputs)
`timescale 1ns/1ps
module alu_exec_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  BranchTaken
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_BEQ = 4'b1000;
   localparam logic [3:0] OP_BNE = 4'b1001;
   localparam logic [3:0] OP_BLT = 4'b1010;
   localparam logic [3:0] OP_BGE = 4'b1011;
   localparam logic [3:0] OP_SLT = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] sreg;
   logic [4:0]            cnt;
   logic                  shift_right;
   logic                  shift_arith;

   logic                  accept;
   logic                  is_shift;
   logic [4:0]            shamt;
   logic                  eq;
   logic                  lt_s;
   logic [DATA_WIDTH-1:0] res_nxt;
   logic                  br_nxt;
   logic [DATA_WIDTH-1:0] shift_step;

   // flush wins over everything, so nothing is accepted in a flush cycle
   assign in_ready = !flush && (state == ST_IDLE || (state == ST_HOLD && out_ready));
   assign accept   = in_valid && in_ready;

   assign shamt    = SrcB[4:0];
   assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
   assign eq       = (SrcA == SrcB);
   assign lt_s     = ($signed(SrcA) < $signed(SrcB));

   // single-bit step of the iterative shifter; arith fills with the sign bit
   assign shift_step = shift_right ? {shift_arith & sreg[DATA_WIDTH-1], sreg[DATA_WIDTH-1:1]}
                                   : {sreg[DATA_WIDTH-2:0], 1'b0};

   // single-cycle result; shift ops only reach here with shamt = 0, which is SrcA unchanged
   always_comb begin
      res_nxt = '0;
      br_nxt  = 1'b0;
      case (Operation)
         OP_AND: res_nxt = SrcA & SrcB;
         OP_OR:  res_nxt = SrcA | SrcB;
         OP_ADD: res_nxt = SrcA + SrcB;
         OP_SUB: res_nxt = SrcA - SrcB;
         OP_XOR: res_nxt = SrcA ^ SrcB;
         OP_SLL, OP_SRL, OP_SRA: res_nxt = SrcA;
         OP_BEQ: begin
            br_nxt  = eq;
            res_nxt = {{(DATA_WIDTH-1){1'b0}}, eq};
         end
         OP_BNE: begin
            br_nxt  = !eq;
            res_nxt = {{(DATA_WIDTH-1){1'b0}}, !eq};
         end
         OP_BLT: begin
            br_nxt  = lt_s;
            res_nxt = {{(DATA_WIDTH-1){1'b0}}, lt_s};
         end
         OP_BGE: begin
            br_nxt  = !lt_s;
            res_nxt = {{(DATA_WIDTH-1){1'b0}}, !lt_s};
         end
         OP_SLT: res_nxt = {{(DATA_WIDTH-1){1'b0}}, lt_s};
         default: begin
            res_nxt = '0;
            br_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         out_valid   <= 1'b0;
         ALUResult   <= '0;
         BranchTaken <= 1'b0;
         sreg        <= '0;
         cnt         <= '0;
         shift_right <= 1'b0;
         shift_arith <= 1'b0;
      end else if (flush) begin
         // result registers keep their last value; only the handshake state is killed
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         cnt       <= '0;
      end else if (accept) begin
         // covers IDLE accept and the back-to-back accept out of HOLD
         if (is_shift && shamt != 5'd0) begin
            sreg        <= SrcA;
            cnt         <= shamt;
            shift_right <= (Operation != OP_SLL);
            shift_arith <= (Operation == OP_SRA);
            out_valid   <= 1'b0;
            state       <= ST_SHIFT;
         end else begin
            ALUResult   <= res_nxt;
            BranchTaken <= br_nxt;
            out_valid   <= 1'b1;
            state       <= ST_HOLD;
         end
      end else begin
         case (state)
            ST_SHIFT: begin
               sreg <= shift_step;
               cnt  <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  ALUResult   <= shift_step;
                  BranchTaken <= 1'b0;
                  out_valid   <= 1'b1;
                  state       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: scoreboard of expected {BranchTaken, ALUResult} pushed at issue,
// popped by a monitor on every completed output handshake, plus directed latency,
// backpressure, flush and reset checks.
`timescale 1ns/1ps
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        BranchTaken;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [32:0] sbq[$];

   alu_exec_unit #(.DATA_WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .Operation   (Operation),
      .SrcA        (SrcA),
      .SrcB        (SrcB),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ALUResult   (ALUResult),
      .BranchTaken (BranchTaken)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // reference model: {BranchTaken, ALUResult}
   function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      logic        br;
      logic [4:0]  sh;
      r  = 32'h0;
      br = 1'b0;
      sh = b[4:0];
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd3:  r = a - b;
         4'd4:  r = a ^ b;
         4'd5:  r = a << sh;
         4'd6:  r = a >> sh;
         4'd7:  r = $signed(a) >>> sh;
         4'd8:  br = (a == b);
         4'd9:  br = (a != b);
         4'd10: br = ($signed(a) < $signed(b));
         4'd11: br = !($signed(a) < $signed(b));
         4'd12: r = {31'b0, ($signed(a) < $signed(b))};
         default: r = 32'h0;
      endcase
      if (op[3:2] == 2'b10) r = {31'b0, br};
      return {br, r};
   endfunction

   // monitor: a result is consumed at the next rising edge when valid & ready & no flush
   always @(negedge clk) begin
      logic [32:0] e;
      if (reset && !flush && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            chk("unexpected_out", 32'(out_valid), 32'h0);
         end else begin
            e = sbq.pop_front();
            chk("sb_result", ALUResult, e[31:0]);
            chk("sb_branch", 32'(BranchTaken), 32'(e[32]));
         end
      end
   end

   // drive one op from posedge+1; returns at posedge+1 after it was accepted
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, output int acc_cyc);
      int n;
      n = 0;
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'h1);
      else if (push) sbq.push_back(model(op, a, b));
      @(posedge clk);
      acc_cyc = cyc;
      #1;
      in_valid = 1'b0;
   endtask

   // cycles from accept to out_valid, and how many of them had in_ready low
   task automatic wait_out(output int lat, output int lowrdy);
      lat    = 0;
      lowrdy = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!in_ready) lowrdy++;
      end while (!out_valid && lat < 100);
      if (!out_valid) chk("out_timeout", 32'(out_valid), 32'h1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  a1, a2, lat, lowrdy;
      bit  seen;
      logic [31:0] ra, rb;
      logic [3:0]  rop;

      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      Operation = 4'h0;
      SrcA      = 32'h0;
      SrcB      = 32'h0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_result", ALUResult, 32'h0);
      chk("rst_branch", 32'(BranchTaken), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;

      // ADD wraparound, back-to-back
      send(4'd2, 32'h7FFF_FFFF, 32'h1, 1'b1, a1);
      send(4'd2, 32'hFFFF_FFFF, 32'h1, 1'b1, a2);
      chk("add_b2b_gap", a2 - a1, 32'd1);
      @(negedge clk);
      chk("add2_vld", 32'(out_valid), 32'h1);
      chk("add2_res", ALUResult, 32'h0);
      @(posedge clk);
      #1;

      // branches
      send(4'd10, 32'hFFFF_FFFF, 32'h1, 1'b1, a1);
      wait_out(lat, lowrdy);
      chk("blt_lat", lat, 32'd1);
      send(4'd11, 32'hFFFF_FFFF, 32'h1, 1'b1, a1);
      wait_out(lat, lowrdy);
      send(4'd8, 32'd5, 32'd5, 1'b1, a1);
      wait_out(lat, lowrdy);
      send(4'd12, 32'h8000_0000, 32'h1, 1'b1, a1);
      wait_out(lat, lowrdy);

      // shifts
      send(4'd7, 32'h8000_0000, 32'h24, 1'b1, a1);
      wait_out(lat, lowrdy);
      chk("sra4_lat", lat, 32'd5);
      chk("sra4_inrdy_low", lowrdy, 32'd4);
      send(4'd5, 32'h1234_5678, 32'h20, 1'b1, a1);
      wait_out(lat, lowrdy);
      chk("sll0_lat", lat, 32'd1);
      send(4'd6, 32'h8000_0000, 32'd31, 1'b1, a1);
      wait_out(lat, lowrdy);
      chk("srl31_lat", lat, 32'd32);
      chk("srl31_inrdy_low", lowrdy, 32'd31);

      // backpressure
      out_ready = 1'b0;
      send(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1, a1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_vld", 32'(out_valid), 32'h1);
         chk("bp_res", ALUResult, 32'h0F0F_F0F0);
         chk("bp_in_rdy", 32'(in_ready), 32'h0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(4'd1, 32'h0000_0012, 32'h0000_0300, 1'b1, a2);
      chk("bp_b2b_gap", a2 - a1, 32'd4);
      wait_out(lat, lowrdy);

      // flush mid-shift
      send(4'd5, 32'h1, 32'd10, 1'b0, a1);
      repeat (3) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("flush_shift_no_vld", 32'(seen), 32'h0);
      chk("flush_shift_in_rdy", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;

      // flush together with in_valid: nothing accepted
      Operation = 4'd2;
      SrcA      = 32'd1;
      SrcB      = 32'd1;
      in_valid  = 1'b1;
      flush     = 1'b1;
      @(negedge clk);
      chk("flush_in_rdy", 32'(in_ready), 32'h0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_no_vld", 32'(out_valid), 32'h0);
      @(posedge clk);
      #1;

      // random traffic through the scoreboard
      for (int i = 0; i < 30; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
         send(rop, ra, rb, 1'b1, a1);
      end
      wait_out(lat, lowrdy);

      // async reset in the middle of a shift
      send(4'd2, 32'd3, 32'd4, 1'b1, a1);
      wait_out(lat, lowrdy);
      send(4'd5, 32'h1, 32'd20, 1'b0, a1);
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("midrst_vld", 32'(out_valid), 32'h0);
      chk("midrst_res", ALUResult, 32'h0);
      chk("midrst_br", 32'(BranchTaken), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_in_rdy", 32'(in_ready), 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_discard", 32'(seen), 32'h0);

      lat = 0;
      while (sbq.size() != 0 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("sb_drain", sbq.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
